// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared constants and FSM encoding for the binary-to-BCD converter
package bin2bcd_seq_pkg;

  localparam int DIGITS    = 4;
  localparam int BCD_W     = 16;
  localparam int MAX_BIN_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_LATCH = 2'b10
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_dd_add3.sv
// rtl/bin2bcd_seq_dd_add3.sv - one double-dabble digit correction: add 3 when the digit is 5 or more
module dd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Digits never exceed 9 here, so the 4-bit sum cannot wrap.
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary-to-BCD converter feeding the 4-digit display
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W = 10
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output logic             ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  sreg_q;
  logic [BCD_W-1:0]  scratch_q;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt_q;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    dd_add3 u_add3 (
      .din  (scratch_q[4*d +: 4]),
      .dout (adj[4*d +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST_SHIFT) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs only move on the LATCH edge so the display never sees a partial word.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q    <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sreg_q    <= bin;
            scratch_q <= '0;
            cnt_q     <= '0;
          end
        end
        ST_SHIFT: begin
          scratch_q <= {adj[BCD_W-2:0], sreg_q[BIN_W-1]};
          sreg_q    <= {sreg_q[BIN_W-2:0], 1'b0};
          cnt_q     <= cnt_q + 1'b1;
        end
        ST_LATCH: begin
          bcd  <= scratch_q;
          ovf  <= (scratch_q[15:12] != 4'd0);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter that uses the shift-add-3 (double-dabble) method. It sits directly upstream of the 4-digit seven-segment controller. It takes the unsigned binary result of the pipelined ALU and produces the packed 16-bit BCD word that the display controller consumes. One conversion takes BIN_W+1 clocks after start, and the output word holds steady between conversions.

Parameters:
BIN_W, 10, width of the binary input; legal range 4..13, so the value always fits in 4 BCD digits.
DIGITS, 4, number of BCD digits produced; fixed at 4 (16-bit bcd).

Ports:
clk1  in  1  system clock; all logic on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request pulse; sampled only in IDLE.
bin  in  BIN_W  unsigned binary value; sampled on the accepting edge only.
busy  out  1  high while a conversion is in progress (state != IDLE).
done  out  1  one-cycle pulse; bcd and ovf are updated in the same cycle.
bcd  out  16  packed BCD: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
ovf  out  1  high when the thousands digit is nonzero (value > 999, exceeds the 3-digit numeric display).

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; busy=0; done=0; bcd=16'h0000; ovf=0.
  - Shift register, scratch register and counter are all cleared.
- FSM states are IDLE, SHIFT and LATCH.
- IDLE, with start=1 at edge E0:
  - Load sreg<=bin, scratch<=0, cnt<=0.
  - Go to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, once per edge:
  - For each scratch digit >=5, add 3 (4-bit result, no carry between digits).
  - Then shift {scratch,sreg} left by 1 bit.
  - cnt<=cnt+1.
  - After BIN_W shifts (edge E_BIN_W) go to LATCH.
- LATCH, at edge E(BIN_W+1):
  - bcd<=scratch; ovf<=(scratch[15:12]!=0); done<=1.
  - Go to IDLE.
- done deasserts on the following edge. It is never high for two consecutive cycles.
- Latency: with the default BIN_W=10, start sampled at E0 gives done=1 and valid bcd after E11.
- Throughput: a start sampled in the cycle where done=1 is accepted, because the FSM is already in IDLE. Back-to-back conversions therefore repeat every BIN_W+2 cycles.
- start while busy=1 is ignored. It is neither queued nor does it corrupt the conversion. bin changes during SHIFT have no effect.
- bcd and ovf change only on a LATCH edge or on reset. They hold their old value throughout a conversion, so the downstream display never sees partial results.
- Width rules:
  - scratch is 16 bits; cnt is ceil(log2(BIN_W+1)) bits.
  - Every output digit is in the range 0..9 for any legal input.
- Boundaries:
  - bin=0 gives 16'h0000.
  - bin=2^BIN_W-1 gives the correct BCD (for BIN_W=10, 1023 gives 16'h1023 with ovf=1).
- Reset mid-conversion aborts immediately. After release the FSM is in IDLE and needs a fresh start; the previous bcd is not restored.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'b00, SHIFT=2'b01, LATCH=2'b10).
  - DIGITS=4 and BCD_W=16.
  - MAX_BIN_W=13.
- One natural sub-module, dd_add3: a 4-bit combinational block that outputs in+3 if in>=5, else passes in through. It is instantiated DIGITS times on scratch.
- The FSM, counter and registers stay in bin2bcd_seq.

Test Plan:
1. Reset, then bin=0 with start pulsed at E0 -> done=1 after E11 only; bcd=16'h0000; ovf=0; busy=1 after E1..E10.
2. bin=999 -> bcd=16'h0999, ovf=0. Then bin=1000 -> bcd=16'h1000, ovf=1. Then bin=1023 -> bcd=16'h1023, ovf=1.
3. bin=437 with start; at E4 pulse start with bin=12 -> single done, bcd=16'h0437, and no second conversion follows.
4. bin=255 converts and is held (bcd=16'h0255). Start bin=800, then assert rst_n=0 at E5 -> bcd=16'h0000, busy=0, done=0 immediately. After release, done stays low until a new start.
5. Back-to-back: start bin=58; re-pulse start with bin=901 in the done cycle -> first result 16'h0058; second done exactly 12 cycles later with 16'h0901.
6. Exhaustive sweep of bin 0..1023 -> each result matches a reference decimal conversion, with ovf=(bin>999).
